signed_accumulator: RTL and testbench
=====================================

// Module: signed_accumulator
// PURPOSE
//  Downstream consumer of the sign-changer stage: accepts a stream of signed two's-complement
//  operands (already negated or passed through upstream) and sums them into a batch result.
//  Detects per-add signed overflow, folds in the upstream negation-overflow flag, and
//  optionally saturates. Presents one result per batch over a valid/ready handshake.
// PARAMETERS
//  WIDTH     8   operand / accumulator width in bits (two's complement)
//  MAX_OPS   16  operands per batch; batch closes automatically when this count is reached
//  SATURATE  0   0: sum wraps modulo 2^WIDTH; 1: sum clamps to +max / -min on overflow
// PORTS
//  clk        in   1                 single clock, all state on rising edge
//  rst        in   1                 synchronous, active-high reset
//  in_data    in   WIDTH             operand from sign-changer output d
//  in_neg_ok  in   1                 sign-changer ovfl: 1 = negation valid, 0 = negating -2^(WIDTH-1)
//  in_valid   in   1                 operand present
//  in_last    in   1                 operand is last of batch (qualified by in_valid)
//  in_ready   out  1                 block can accept operand
//  out_sum    out  WIDTH             batch sum
//  out_ovfl   out  1                 sticky: any add overflow or any in_neg_ok=0 in batch
//  out_count  out  $clog2(MAX_OPS+1) operands accepted in batch
//  out_valid  out  1                 result present
//  out_ready  in   1                 consumer takes result
// BEHAVIOUR
//  - Reset (rst=1 at edge): state=IDLE, acc=0, count=0, sticky=0, out_valid=0, out_sum=0,
//    out_ovfl=0, out_count=0. Reset mid-batch or mid-DONE aborts; result is discarded.
//  - in_ready = (state!=DONE); combinational from state only, never from in_valid.
//  - Accept = in_valid & in_ready. Per accepted beat:
//    sum_ext = sx(acc)+sx(in_data) at WIDTH+1 bits; add_ovf = (acc[MSB]==in_data[MSB]) &
//    (sum[MSB]!=acc[MSB]). acc <= SATURATE&add_ovf ? (acc[MSB] ? -2^(WIDTH-1) : 2^(WIDTH-1)-1)
//    : sum[WIDTH-1:0]. sticky <= sticky | add_ovf | ~in_neg_ok. count <= count+1.
//  - FSM:
//    IDLE: accept -> ACC; accept & (in_last | MAX_OPS==1) -> DONE.
//    ACC : accept & (in_last | count+1==MAX_OPS) -> DONE; else stay.
//    DONE: out_valid=1, outputs hold stable; out_ready -> IDLE with acc, count, sticky cleared.
//  - Latency: result valid the cycle after the closing beat is accepted. Re-accept is possible
//    the cycle after the out handshake; max throughput one batch per (N+1) cycles.
//  - out_sum/out_ovfl/out_count are registered and change only when entering DONE
//    (loaded with final values) or on reset; never glitch while out_valid=1.
//  - in_last with in_valid=0 is ignored. in_data is ignored when not accepted.
//  - count never exceeds MAX_OPS; after wrap/saturation, further adds continue from the
//    wrapped/clamped acc value.
//  - out_valid is never asserted in the same cycle as in_ready.
// STRUCTURE
//  - Shared header acc_defs.vh: state encodings (IDLE=2'd0, ACC=2'd1, DONE=2'd2) and
//    macros for WIDTH-parametrised MAX_POS / MIN_NEG clamp constants.
//  - One sub-module: reuse the existing add8 ripple adder (A, B, Cin=0, S, Cout) for
//    WIDTH=8; overflow and clamp logic stay inline. Generate a behavioural '+' when WIDTH!=8.
//  - FSM, counter, sticky flag and output registers live in this module.
// TESTING
//  1. Reset, then 3 beats 5, -3 (0xFD), 10 with last on 3rd -> out_sum=12, ovfl=0, count=3,
//     out_valid the cycle after beat 3; in_ready=0 while out_valid.
//  2. SATURATE=0: 100 + 100 (last) -> out_sum=0xC8 (-56), out_ovfl=1; SATURATE=1 -> 0x7F, ovfl=1.
//  3. SATURATE=1: -100 + -100 (last) -> out_sum=0x80, ovfl=1; then +1 in next batch -> 1, ovfl=0
//     (sticky cleared by the out handshake).
//  4. in_neg_ok=0 with in_data=0x80, then 0x01 last -> out_sum=0x81, out_ovfl=1.
//  5. MAX_OPS=16, 16 beats of 1, in_last never set -> DONE after 16th, out_sum=16, count=16.
//  6. out_ready held low 5 cycles in DONE -> outputs stable, in_ready=0; rst pulsed mid-ACC
//     after 2 beats -> out_valid=0, next batch 7 (last) gives out_sum=7, count=1.

Source files
------------

// File: rtl/signed_accumulator_pkg.sv
// Shared types and constants for the signed batch accumulator.
package signed_accumulator_pkg;

    // Batch FSM states. The encodings are fixed because existing logic relies on them.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } acc_state_t;

    // Operand width served by the reusable ripple adder.
    localparam int ADD8_WIDTH = 8;

endpackage : signed_accumulator_pkg

// File: rtl/signed_accumulator_add8.sv
// 8-bit ripple-carry adder built from a chain of full adders.
module add8 (
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       Cin,
    output logic [7:0] S,
    output logic       Cout
);

    logic [8:0] w_carry;

    assign w_carry[0] = Cin;

    for (genvar g = 0; g < 8; g++) begin : g_fa
        assign S[g]         = A[g] ^ B[g] ^ w_carry[g];
        assign w_carry[g+1] = (A[g] & B[g]) | (w_carry[g] & (A[g] ^ B[g]));
    end

    assign Cout = w_carry[8];

endmodule : add8

// File: rtl/signed_accumulator.sv
// Sums a stream of signed operands into one result per batch, with sticky overflow
// tracking, optional saturation and valid/ready handshakes on both sides.
module signed_accumulator
    import signed_accumulator_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MAX_OPS  = 16,
    parameter bit SATURATE = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WIDTH-1:0]             in_data,
    input  logic                         in_neg_ok,
    input  logic                         in_valid,
    input  logic                         in_last,
    output logic                         in_ready,
    output logic [WIDTH-1:0]             out_sum,
    output logic                         out_ovfl,
    output logic [$clog2(MAX_OPS+1)-1:0] out_count,
    output logic                         out_valid,
    input  logic                         out_ready
);

    localparam int CW = $clog2(MAX_OPS + 1);
    localparam logic [CW-1:0]    MAX_CNT = CW'(MAX_OPS);
    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    acc_state_t       r_state;
    logic [WIDTH-1:0] r_acc;
    logic [CW-1:0]    r_count;
    logic             r_sticky;

    logic [WIDTH:0]   w_sum_ext;
    logic             w_add_ovf;
    logic [WIDTH-1:0] w_acc_next;
    logic [CW-1:0]    w_count_next;
    logic             w_sticky_next;
    logic             w_accept;
    logic             w_close;

    if (WIDTH == ADD8_WIDTH) begin : g_add8
        logic [WIDTH-1:0] w_s;
        logic             w_cout;

        add8 u_add8 (
            .A    (r_acc),
            .B    (in_data),
            .Cin  (1'b0),
            .S    (w_s),
            .Cout (w_cout)
        );

        // Top bit of the sign-extended sum recovered from the unsigned carry-out.
        assign w_sum_ext = {r_acc[WIDTH-1] ^ in_data[WIDTH-1] ^ w_cout, w_s};
    end else begin : g_add_beh
        assign w_sum_ext = {r_acc[WIDTH-1], r_acc} + {in_data[WIDTH-1], in_data};
    end

    assign w_add_ovf = (r_acc[WIDTH-1] == in_data[WIDTH-1]) &&
                       (w_sum_ext[WIDTH-1] != r_acc[WIDTH-1]);

    always_comb begin
        w_acc_next = w_sum_ext[WIDTH-1:0];
        if (SATURATE && w_add_ovf) begin
            w_acc_next = r_acc[WIDTH-1] ? MIN_NEG : MAX_POS;
        end
    end

    assign in_ready      = (r_state != ST_DONE);
    assign w_accept      = in_valid && in_ready;
    assign w_count_next  = r_count + 1'b1;
    assign w_sticky_next = r_sticky | w_add_ovf | ~in_neg_ok;
    // Counting from zero in IDLE makes this also cover MAX_OPS == 1.
    assign w_close       = in_last || (w_count_next == MAX_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_acc     <= '0;
            r_count   <= '0;
            r_sticky  <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_ovfl  <= 1'b0;
            out_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_ACC: begin
                    if (w_accept) begin
                        r_acc    <= w_acc_next;
                        r_count  <= w_count_next;
                        r_sticky <= w_sticky_next;
                        if (w_close) begin
                            r_state   <= ST_DONE;
                            out_valid <= 1'b1;
                            out_sum   <= w_acc_next;
                            out_ovfl  <= w_sticky_next;
                            out_count <= w_count_next;
                        end else begin
                            r_state <= ST_ACC;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state   <= ST_IDLE;
                        out_valid <= 1'b0;
                        r_acc     <= '0;
                        r_count   <= '0;
                        r_sticky  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : signed_accumulator

// File: tb/tb_signed_accumulator.sv
// Drives a wrapping and a saturating accumulator with shared stimulus and compares both
// against an integer-arithmetic batch model.
module tb_signed_accumulator;

    localparam int W  = 8;
    localparam int N  = 16;
    localparam int CW = $clog2(N + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  in_data = '0;
    logic          in_neg_ok = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic          out_ready = 1'b0;

    logic          rdy_w, rdy_s, vld_w, vld_s, ovf_w, ovf_s;
    logic [W-1:0]  sum_w, sum_s;
    logic [CW-1:0] cnt_w, cnt_s;

    int n_checks = 0;
    int n_errors = 0;

    int q_data[$];
    bit q_nok[$];
    bit m_done = 1'b0;
    int e_sum_w, e_sum_s, e_cnt;
    bit e_ovf_w, e_ovf_s;

    always #5 clk = ~clk;

    signed_accumulator #(.WIDTH(W), .MAX_OPS(N), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .in_data(in_data), .in_neg_ok(in_neg_ok),
        .in_valid(in_valid), .in_last(in_last), .in_ready(rdy_w),
        .out_sum(sum_w), .out_ovfl(ovf_w), .out_count(cnt_w),
        .out_valid(vld_w), .out_ready(out_ready)
    );

    signed_accumulator #(.WIDTH(W), .MAX_OPS(N), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst(rst), .in_data(in_data), .in_neg_ok(in_neg_ok),
        .in_valid(in_valid), .in_last(in_last), .in_ready(rdy_s),
        .out_sum(sum_s), .out_ovfl(ovf_s), .out_count(cnt_s),
        .out_valid(vld_s), .out_ready(out_ready)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Batch result from plain integer arithmetic on the recorded operands.
    task automatic model_batch(input bit sat, output int sum, output bit ovf);
        int acc = 0;
        int s;
        ovf = 1'b0;
        foreach (q_data[i]) begin
            s = acc + q_data[i];
            if (s > 127 || s < -128) begin
                ovf = 1'b1;
                if (sat) s = (s > 127) ? 127 : -128;
                else     s = (s > 127) ? s - 256 : s + 256;
            end
            acc = s;
            if (!q_nok[i]) ovf = 1'b1;
        end
        sum = acc & 32'hFF;
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, "_vld_w"}, vld_w, m_done);
        check_eq({tag, "_vld_s"}, vld_s, m_done);
        check_eq({tag, "_rdy_w"}, rdy_w, !m_done);
        check_eq({tag, "_rdy_s"}, rdy_s, !m_done);
        if (m_done) begin
            check_eq({tag, "_sum_w"}, sum_w, e_sum_w);
            check_eq({tag, "_sum_s"}, sum_s, e_sum_s);
            check_eq({tag, "_ovf_w"}, ovf_w, e_ovf_w);
            check_eq({tag, "_ovf_s"}, ovf_s, e_ovf_s);
            check_eq({tag, "_cnt_w"}, cnt_w, e_cnt);
            check_eq({tag, "_cnt_s"}, cnt_s, e_cnt);
        end
    endtask

    task automatic beat(input logic [W-1:0] d, input bit nok, input bit last);
        check_eq("pre_rdy", rdy_w & rdy_s, 1);
        in_data   = d;
        in_neg_ok = nok;
        in_last   = last;
        in_valid  = 1'b1;
        q_data.push_back(int'($signed(d)));
        q_nok.push_back(nok);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_neg_ok = 1'b1;
        in_data   = W'($urandom);
        if (last || q_data.size() == N) begin
            m_done = 1'b1;
            e_cnt  = q_data.size();
            model_batch(1'b0, e_sum_w, e_ovf_w);
            model_batch(1'b1, e_sum_s, e_ovf_s);
            check_outputs("close");
        end else begin
            check_eq("open_vld", vld_w | vld_s, 0);
        end
    endtask

    // Idle cycles with junk on the input bus; in DONE a valid beat must also be refused.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            in_data  = W'($urandom);
            in_last  = 1'($urandom);
            in_valid = m_done ? 1'($urandom) : 1'b0;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            in_last  = 1'b0;
            check_outputs("idle");
        end
    endtask

    task automatic take(input int hold);
        idle(hold);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        m_done    = 1'b0;
        q_data.delete();
        q_nok.delete();
        check_outputs("take");
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        m_done = 1'b0;
        q_data.delete();
        q_nok.delete();
        check_outputs("rst");
        check_eq("rst_sum", sum_w | sum_s, 0);
        check_eq("rst_cnt", cnt_w | cnt_s, 0);
        check_eq("rst_ovf", ovf_w | ovf_s, 0);
    endtask

    initial begin
        int len;
        bit use_last;
        logic [W-1:0] d;

        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Three-beat batch with a negative operand.
        beat(8'd5, 1, 0);
        beat(8'hFD, 1, 0);
        beat(8'd10, 1, 1);
        check_eq("t1_sum", sum_w, 12);
        check_eq("t1_cnt", cnt_w, 3);
        take(1);

        // Positive overflow: wraps to 0xC8, clamps to 0x7F.
        beat(8'd100, 1, 0);
        beat(8'd100, 1, 1);
        check_eq("t2_sum_w", sum_w, 8'hC8);
        check_eq("t2_sum_s", sum_s, 8'h7F);
        take(0);

        // Negative overflow, then a clean batch must show a cleared sticky flag.
        beat(8'h9C, 1, 0);
        beat(8'h9C, 1, 1);
        check_eq("t3_sum_s", sum_s, 8'h80);
        check_eq("t3_sum_w", sum_w, 8'h38);
        take(0);
        beat(8'd1, 1, 1);
        check_eq("t3b_ovf", ovf_w | ovf_s, 0);
        take(0);

        // Upstream negation-overflow folds into the sticky flag.
        beat(8'h80, 0, 0);
        beat(8'h01, 1, 1);
        check_eq("t4_sum", sum_w, 8'h81);
        check_eq("t4_ovf", ovf_w, 1);
        take(0);

        // Batch closes at MAX_OPS without in_last.
        for (int i = 0; i < N; i++) beat(8'd1, 1, 0);
        check_eq("t5_cnt", cnt_w, 16);
        check_eq("t5_sum", sum_w, 16);

        // Consumer stall, then reset aborting an open batch.
        take(5);
        beat(8'd20, 1, 0);
        beat(8'd30, 1, 0);
        do_reset();
        beat(8'd7, 1, 1);
        check_eq("t6_sum", sum_w, 7);
        check_eq("t6_cnt", cnt_w, 1);
        take(0);

        for (int b = 0; b < 40; b++) begin
            len      = $urandom_range(1, N);
            use_last = ($urandom_range(0, 3) != 0);
            if (!use_last) len = N;
            for (int i = 0; i < len; i++) begin
                idle($urandom_range(0, 2));
                if ($urandom_range(0, 3) == 0) d = $urandom_range(0, 1) ? 8'h80 : 8'h7F;
                else                           d = W'($urandom);
                beat(d, ($urandom_range(0, 7) != 0), use_last && (i == len - 1));
            end
            take($urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_signed_accumulator
